// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop sync, debounce, press/release/repeat pulses (repeat only with BUTTON_CONDITIONER_AUTOREPEAT_EN).
// Latency: pb_state/pb_down/pb_up change 2+DB_CYCLES rising edges after a clean pb_n transition.
// Backpressure: none; outputs are free-running registered pulses and levels.
module button_conditioner #(
    parameter int DB_CYCLES  = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pb_n,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_rpt
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 2 || DB_CYCLES > (1 << 20) || RPT_DELAY < 2 || RPT_PERIOD < 2) begin : g_bad_params
            $error("button_conditioner: parameter out of legal range");
        end
    endgenerate

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] db_cnt;
    logic            sync_pressed;
    logic            db_toggle;

    assign sync_pressed = ~sync_q2;
    assign db_toggle    = (sync_pressed != pb_state) && (db_cnt == DB_MAX);

    // Counter only advances while the synchronized level disagrees with pb_state,
    // so any bounce back to the current state restarts the count from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            db_cnt   <= '0;
            pb_state <= 1'b0;
            pb_down  <= 1'b0;
            pb_up    <= 1'b0;
        end else begin
            sync_q1 <= pb_n;
            sync_q2 <= sync_q1;
            pb_down <= 1'b0;
            pb_up   <= 1'b0;
            if (sync_pressed == pb_state) begin
                db_cnt <= '0;
            end else if (db_toggle) begin
                db_cnt   <= '0;
                pb_state <= ~pb_state;
                pb_down  <= ~pb_state;
                pb_up    <= pb_state;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(RPT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // The release edge (pb_state 1 with db_toggle) clears the count so no repeat
    // can coincide with or follow pb_up.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
            pb_rpt    <= 1'b0;
        end else begin
            pb_rpt <= 1'b0;
            if (!pb_state || db_toggle) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT)) begin
                pb_rpt    <= 1'b1;
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign pb_rpt = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3.
// Expected pulses are queued per absolute edge number and checked every cycle.
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = 2 + DB;

    logic clock = 1'b0;
    logic reset_n;
    logic pb_n;
    logic pb_state, pb_down, pb_up, pb_rpt;

    button_conditioner #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .pb_n    (pb_n),
        .pb_state(pb_state),
        .pb_down (pb_down),
        .pb_up   (pb_up),
        .pb_rpt  (pb_rpt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {rpt, up, down}
    } ev_t;

    typedef struct {
        int low_len;
        int high_len;
        bit exp_press;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[8];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic exp_state = 1'b0;
    logic [2:0] exp_p;
    logic [2:0] obs_p;

    function automatic void push(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endfunction

    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            exp_p = 3'b000;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                if (sb[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_event: still queued at edge %0d, required at edge %0d", cyc, sb[0].cyc);
                end else begin
                    exp_p = exp_p | sb[0].kind;
                end
                void'(sb.pop_front());
            end
            if (exp_p[0]) exp_state = 1'b1;
            if (exp_p[1]) exp_state = 1'b0;
            obs_p = {pb_rpt, pb_up, pb_down};
            checks++;
            if (obs_p !== exp_p) begin
                errors++;
                $display("FAIL pulses edge %0d: {rpt,up,down} actual=%b required=%b", cyc, obs_p, exp_p);
            end
            checks++;
            if (pb_state !== exp_state) begin
                errors++;
                $display("FAIL pb_state edge %0d: actual=%b required=%b", cyc, pb_state, exp_state);
            end
        end
    end

    task automatic check_reset(input string name);
        checks++;
        if ({pb_state, pb_down, pb_up, pb_rpt} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: {state,down,up,rpt} actual=%b required=0000", name,
                     {pb_state, pb_down, pb_up, pb_rpt});
        end
    endtask

    // Drives pb_n low for low_len cycles then high for high_len, queuing the
    // pulses a recognised press must produce relative to the starting edge.
    task automatic apply_vec(input vec_t v);
        int n;
        int p;
        n = cyc;
        pb_n = 1'b0;
        if (v.exp_press) begin
            p = n + LAT;
            push(p, 3'b001);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            for (int t = p + RD; t < n + v.low_len + LAT; t += RP) push(t, 3'b100);
`endif
            push(n + v.low_len + LAT, 3'b010);
        end
        repeat (v.low_len) @(negedge clock);
        pb_n = 1'b1;
        repeat (v.high_len) @(negedge clock);
    endtask

    initial begin
        vec_t v;
        int   n;
        vecs[0] = '{3, 1, 1'b0};
        vecs[1] = '{3, 12, 1'b0};
        vecs[2] = '{10, 10, 1'b1};
        vecs[3] = '{20, 8, 1'b1};
        vecs[4] = '{36, 10, 1'b1};
        vecs[5] = '{4, 6, 1'b1};
        vecs[6] = '{5, 4, 1'b1};
        vecs[7] = '{2, 5, 1'b0};

        reset_n = 1'b0;
        pb_n    = 1'b1;
        repeat (3) @(negedge clock);
        check_reset("reset_idle");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (50) @(negedge clock);

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Reset in the middle of a debounce, button still held through release.
        pb_n = 1'b0;
        repeat (3) @(negedge clock);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_debounce");
        sb.delete();
        exp_state = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        v = '{12, 8, 1'b1};
        apply_vec(v);

        // Reset while held in the repeat phase; release must not yield pb_up.
        n = cyc;
        pb_n = 1'b0;
        push(n + LAT, 3'b001);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        push(n + LAT + RD, 3'b100);
        push(n + LAT + RD + RP, 3'b100);
`endif
        repeat (20) @(negedge clock);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset("reset_mid_repeat");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL events_before_reset: pending actual=%0d required=0", sb.size());
        end
        sb.delete();
        exp_state = 1'b0;
        pb_n = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (20) @(negedge clock);

        v = '{6, 10, 1'b1};
        apply_vec(v);
        repeat (10) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: pending actual=%0d required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, meaning consecutive cycles of a changed synchronized input before the debounced state toggles (legal 2..2^20).
REQ-002 SHALL have parameter RPT_DELAY, default 25000000, meaning hold cycles from press pulse to first repeat pulse (legal >=2).
REQ-003 SHALL have parameter RPT_PERIOD, default 5000000, meaning cycles between successive repeat pulses (legal >=2).
REQ-004 SHALL have ports in order:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pb_n  in  1  raw asynchronous pushbutton, 0 = pressed.
- pb_state  out  1  debounced level, 1 = pressed.
- pb_down  out  1  one-cycle press pulse.
- pb_up  out  1  one-cycle release pulse; drives the counter enable downstream.
- pb_rpt  out  1  one-cycle auto-repeat pulse.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL pass pb_n through a 2-flop synchronizer; no other logic may sample pb_n.
REQ-007 SHALL hold a debounce counter, width ceil(log2(DB_CYCLES)), cleared on any cycle the synchronized value equals the debounced state.
REQ-008 SHALL increment the counter each cycle the synchronized value differs from the debounced state; when it reaches DB_CYCLES-1 while still differing, it clears and pb_state toggles at that edge.
REQ-009 SHALL make pb_state change exactly 2+DB_CYCLES rising edges after a clean pb_n transition.
REQ-010 SHALL ignore any bounce shorter than DB_CYCLES synchronized cycles; the counter restarts from 0 after each bounce.
REQ-011 SHALL assert pb_down for exactly one cycle, the first cycle pb_state is 1; pb_up likewise for the first cycle pb_state is 0 after a 1.
REQ-012 SHALL never assert pb_down and pb_up in the same cycle; all outputs registered, no combinational path from pb_n.
REQ-013 SHALL not saturate or wrap the debounce counter; it never exceeds DB_CYCLES-1.

Reset
REQ-014 SHALL on reset_n low immediately set synchronizer flops to 1 (released), debounce and repeat counters to 0, pb_state, pb_down, pb_up, pb_rpt to 0.
REQ-015 SHALL, when reset asserts mid-debounce or mid-repeat, discard progress with no pulse on deassertion.
REQ-016 SHALL, if pb_n is held 0 through reset release, produce one pb_down 2+DB_CYCLES edges after release.

Configuration
REQ-017 SHALL compile auto-repeat only when macro BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
REQ-018 SHALL, with macro defined, run a repeat counter while pb_state=1: first pb_rpt RPT_DELAY cycles after the pb_down cycle, then every RPT_PERIOD cycles while held.
REQ-019 SHALL, with macro defined, clear the repeat counter in the pb_up cycle; no pb_rpt is emitted in or after the pb_up cycle.
REQ-020 SHALL, without macro, tie pb_rpt to 0 and omit the repeat counter; all other behaviour identical.

Verification (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3)
REQ-021 SHALL cover reset: reset_n=0 with pb_n=1 -> all outputs 0; release, hold pb_n=1 for 50 cycles -> no pulses.
REQ-022 SHALL cover clean press: pb_n 1->0 at edge N -> pb_state=1 and pb_down=1 at edge N+6, pb_down=0 at N+7.
REQ-023 SHALL cover bounce: pb_n low 3 cycles, high 1, low 3, high -> pb_state stays 0, no pulses; then low 10 cycles -> one pb_down.
REQ-024 SHALL cover release: press held 20 cycles, pb_n 0->1 at edge M -> pb_up=1 exactly at M+6, one cycle, pb_state=0.
REQ-025 SHALL cover auto-repeat (macro defined): hold 30 cycles after pb_down at edge P -> pb_rpt at P+10, P+13, P+16 ... until pb_up; macro undefined -> pb_rpt never 1.
REQ-026 SHALL cover reset mid-debounce: pb_n 0 for 3 cycles then reset_n pulse low -> outputs 0, and with pb_n still 0, pb_down 6 edges after reset release.
